// File: rtl/jtbubl_pkg.sv
// Shared register map and status constants for the sound-side communication block.
package jtbubl_pkg;

    localparam logic [1:0] REG_LATCH   = 2'd0;
    localparam logic [1:0] REG_NMI_ON  = 2'd1;
    localparam logic [1:0] REG_NMI_OFF = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd1;

    localparam logic [5:0] STATUS_PAD  = 6'h3f;
    localparam logic [7:0] BUS_IDLE    = 8'hff;

    function automatic logic [7:0] status_byte(input logic main_flag, input logic snd_flag);
        return {STATUS_PAD, main_flag, snd_flag};
    endfunction

endpackage

// File: rtl/jtbubl_edge.sv
// Registered rising-edge detector; the history register resets to RST_HIST so a
// level that is already high out of reset does not fire.
module jtbubl_edge #(
    parameter logic RST_HIST = 1'b1
) (
    input  logic clk24,
    input  logic rst_n,
    input  logic clr,
    input  logic din,
    output logic rise
);

    logic hist_q;
    logic hist_d;

    assign hist_d = clr ? RST_HIST : din;

    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) hist_q <= RST_HIST;
        else        hist_q <= hist_d;
    end

    assign rise = din & ~hist_q;

endmodule

// File: rtl/jtbubl_snd_comm.sv
// Sound-CPU side of the main/sound mailbox: latches in both directions,
// pending flag, NMI generation and the 0xB000-0xB003 register window.
module jtbubl_snd_comm
    import jtbubl_pkg::*;
#(
    parameter logic NMI_DEF = 1'b0
) (
    input  logic       clk24,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       snd_rstn,
    input  logic [7:0] snd_latch,
    input  logic       snd_stb,
    input  logic       main_flag,
    input  logic       cs,
    input  logic [1:0] addr,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [7:0] cpu_dout,
    output logic [7:0] cpu_din,
    output logic [7:0] main_latch,
    output logic       main_stb,
    output logic       snd_flag,
    output logic       nmi_n
);

    // Everything runs at full clk24 rate; the clock enable is not needed here.
    logic unused_cen;
    assign unused_cen = cen;

    logic       soft_rst;
    logic       acc;
    logic       acc_rise;
    logic       stb_rise;
    logic       rd_edge;
    logic       wr_edge;

    logic [7:0] main_latch_q, main_latch_d;
    logic       main_stb_q,   main_stb_d;
    logic       pending_q,    pending_d;
    logic       nmi_en_q,     nmi_en_d;
    logic       nmi_n_q,      nmi_n_d;
    logic [7:0] cpu_din_q,    cpu_din_d;

    assign soft_rst = ~snd_rstn;
    assign acc      = cs & (~rd_n | ~wr_n);
    assign wr_edge  = acc_rise & ~wr_n;
    assign rd_edge  = acc_rise & ~rd_n & wr_n;

    jtbubl_edge #(.RST_HIST(1'b1)) u_stb_edge (
        .clk24 (clk24),
        .rst_n (rst_n),
        .clr   (soft_rst),
        .din   (snd_stb),
        .rise  (stb_rise)
    );

    jtbubl_edge #(.RST_HIST(1'b1)) u_acc_edge (
        .clk24 (clk24),
        .rst_n (rst_n),
        .clr   (soft_rst),
        .din   (acc),
        .rise  (acc_rise)
    );

    always_comb begin
        main_latch_d = main_latch_q;
        main_stb_d   = 1'b0;
        pending_d    = pending_q;
        nmi_en_d     = nmi_en_q;
        cpu_din_d    = BUS_IDLE;

        if (wr_edge) begin
            case (addr)
                REG_LATCH: begin
                    main_latch_d = cpu_dout;
                    main_stb_d   = 1'b1;
                end
                REG_NMI_ON:  nmi_en_d = 1'b1;
                REG_NMI_OFF: nmi_en_d = 1'b0;
                default: ;
            endcase
        end

        // Read data is captured once per bus cycle and held until rd_n rises.
        if (cs && !rd_n) begin
            if (rd_edge) begin
                case (addr)
                    REG_LATCH: begin
                        cpu_din_d = snd_latch;
                        pending_d = 1'b0;
                    end
                    REG_STATUS: cpu_din_d = status_byte(main_flag, pending_q);
                    default:    cpu_din_d = BUS_IDLE;
                endcase
            end else begin
                cpu_din_d = cpu_din_q;
            end
        end

        // A new byte from the main side beats a simultaneous read of the latch.
        if (stb_rise) pending_d = 1'b1;

        nmi_n_d = ~(pending_d & nmi_en_d);

        if (soft_rst) begin
            main_stb_d = 1'b0;
            pending_d  = 1'b0;
            nmi_en_d   = NMI_DEF;
            nmi_n_d    = 1'b1;
            cpu_din_d  = BUS_IDLE;
        end
    end

    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            main_latch_q <= 8'h00;
            main_stb_q   <= 1'b0;
            pending_q    <= 1'b0;
            nmi_en_q     <= NMI_DEF;
            nmi_n_q      <= 1'b1;
            cpu_din_q    <= BUS_IDLE;
        end else begin
            main_latch_q <= main_latch_d;
            main_stb_q   <= main_stb_d;
            pending_q    <= pending_d;
            nmi_en_q     <= nmi_en_d;
            nmi_n_q      <= nmi_n_d;
            cpu_din_q    <= cpu_din_d;
        end
    end

    assign cpu_din    = cpu_din_q;
    assign main_latch = main_latch_q;
    assign main_stb   = main_stb_q;
    assign snd_flag   = pending_q;
    assign nmi_n      = nmi_n_q;

endmodule

// File: tb/tb_jtbubl_snd_comm.sv
// Bench for jtbubl_snd_comm: directed mailbox scenarios followed by random
// transactions checked against a transaction-level model of the mailbox.
module tb_jtbubl_snd_comm;

    logic       clk24     = 1'b0;
    logic       rst_n     = 1'b1;
    logic       cen       = 1'b0;
    logic       snd_rstn  = 1'b1;
    logic [7:0] snd_latch = 8'h00;
    logic       snd_stb   = 1'b0;
    logic       main_flag = 1'b0;
    logic       cs        = 1'b0;
    logic [1:0] addr      = 2'd0;
    logic       rd_n      = 1'b1;
    logic       wr_n      = 1'b1;
    logic [7:0] cpu_dout  = 8'h00;
    logic [7:0] cpu_din;
    logic [7:0] main_latch;
    logic       main_stb;
    logic       snd_flag;
    logic       nmi_n;

    jtbubl_snd_comm #(.NMI_DEF(1'b0)) dut (
        .clk24      (clk24),
        .rst_n      (rst_n),
        .cen        (cen),
        .snd_rstn   (snd_rstn),
        .snd_latch  (snd_latch),
        .snd_stb    (snd_stb),
        .main_flag  (main_flag),
        .cs         (cs),
        .addr       (addr),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .cpu_dout   (cpu_dout),
        .cpu_din    (cpu_din),
        .main_latch (main_latch),
        .main_stb   (main_stb),
        .snd_flag   (snd_flag),
        .nmi_n      (nmi_n)
    );

    always #5 clk24 = ~clk24;

    int n_checks = 0;
    int n_errors = 0;

    // Mailbox model: what the sound CPU should see, in terms of transactions.
    bit         m_pending = 1'b0;
    bit         m_nmi_en  = 1'b0;
    logic [7:0] m_latch   = 8'h00;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk24);
        #1;
        cen = ~cen;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_flag"},  {7'd0, snd_flag}, {7'd0, m_pending});
        chk({tag, "_nmi"},   {7'd0, nmi_n},    {7'd0, !(m_pending && m_nmi_en)});
        chk({tag, "_latch"}, main_latch,       m_latch);
    endtask

    task automatic stb_event(input logic [7:0] d, input int len);
        snd_latch = d;
        snd_stb   = 1'b1;
        tick();
        m_pending = 1'b1;
        check_state("stb");
        for (int i = 1; i < len; i++) tick();
        check_state("stb_hold");
        snd_stb = 1'b0;
        tick();
        check_state("stb_end");
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d, input int len);
        int pulses;
        pulses   = 0;
        cs       = 1'b1;
        addr     = a;
        cpu_dout = d;
        wr_n     = 1'b0;
        tick();
        case (a)
            2'd0: m_latch  = d;
            2'd1: m_nmi_en = 1'b1;
            2'd2: m_nmi_en = 1'b0;
            default: ;
        endcase
        if (main_stb) pulses++;
        check_state("wr");
        for (int i = 1; i < len; i++) begin
            tick();
            if (main_stb) pulses++;
        end
        cs   = 1'b0;
        wr_n = 1'b1;
        tick();
        if (main_stb) pulses++;
        chk("wr_pulses", 8'(pulses), (a == 2'd0) ? 8'd1 : 8'd0);
        check_state("wr_end");
    endtask

    task automatic cpu_read(input logic [1:0] a, input int len, input bit with_stb, input logic [7:0] d);
        logic [7:0] exp;
        cs   = 1'b1;
        addr = a;
        rd_n = 1'b0;
        if (with_stb) begin
            snd_latch = d;
            snd_stb   = 1'b1;
        end
        if (a == 2'd0)      exp = snd_latch;
        else if (a == 2'd1) exp = {6'h3f, main_flag, m_pending};
        else                exp = 8'hff;
        tick();
        if (a == 2'd0) m_pending = 1'b0;
        if (with_stb)  m_pending = 1'b1;
        chk("rd_data", cpu_din, exp);
        check_state("rd");
        for (int i = 1; i < len; i++) begin
            tick();
            chk("rd_hold", cpu_din, exp);
        end
        cs      = 1'b0;
        rd_n    = 1'b1;
        snd_stb = 1'b0;
        tick();
        chk("rd_idle", cpu_din, 8'hff);
        check_state("rd_end");
    endtask

    task automatic soft_reset(input int len);
        snd_rstn = 1'b0;
        for (int i = 0; i < len; i++) tick();
        m_pending = 1'b0;
        m_nmi_en  = 1'b0;
        check_state("srst");
        chk("srst_din", cpu_din, 8'hff);
        chk("srst_stb", {7'd0, main_stb}, 8'd0);
        snd_rstn = 1'b1;
        tick();
        check_state("srst_end");
    endtask

    initial begin
        int op;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_din",   cpu_din,    8'hff);
        chk("rst_latch", main_latch, 8'h00);
        chk("rst_stb",   {7'd0, main_stb}, 8'd0);
        chk("rst_flag",  {7'd0, snd_flag}, 8'd0);
        chk("rst_nmi",   {7'd0, nmi_n},    8'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_state("post_rst");

        // NMI on, byte arrives, sound CPU reads it back
        cpu_write(2'd1, 8'h00, 2);
        stb_event(8'h5a, 10);
        cpu_read(2'd0, 3, 1'b0, 8'h00);

        // long write strobe produces a single main_stb
        cpu_write(2'd0, 8'hc3, 6);

        // NMI masked while pending, then re-enabled
        cpu_write(2'd2, 8'h00, 1);
        stb_event(8'h11, 2);
        cpu_write(2'd1, 8'h00, 1);

        // new byte coincides with a latch read: set wins
        cpu_read(2'd0, 2, 1'b1, 8'h77);

        // status register with both flags high, then both low
        main_flag = 1'b1;
        cpu_read(2'd1, 2, 1'b0, 8'h00);
        cpu_read(2'd0, 1, 1'b0, 8'h00);
        main_flag = 1'b0;
        cpu_read(2'd1, 2, 1'b0, 8'h00);
        cpu_read(2'd3, 2, 1'b0, 8'h00);

        // soft reset with a byte pending keeps main_latch
        stb_event(8'h42, 1);
        soft_reset(3);

        // hard reset in the middle of a latch write
        cs       = 1'b1;
        addr     = 2'd0;
        cpu_dout = 8'h99;
        wr_n     = 1'b0;
        tick();
        chk("mid_latch", main_latch, 8'h99);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_din",   cpu_din,    8'hff);
        chk("arst_latch", main_latch, 8'h00);
        chk("arst_stb",   {7'd0, main_stb}, 8'd0);
        chk("arst_flag",  {7'd0, snd_flag}, 8'd0);
        chk("arst_nmi",   {7'd0, nmi_n},    8'd1);
        m_pending = 1'b0;
        m_nmi_en  = 1'b0;
        m_latch   = 8'h00;
        cs   = 1'b0;
        wr_n = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        check_state("arst_end");

        for (int n = 0; n < 300; n++) begin
            op = int'($urandom_range(0, 9));
            if (op <= 2) begin
                stb_event(8'($urandom), int'($urandom_range(1, 4)));
            end else if (op <= 5) begin
                cpu_write(2'($urandom), 8'($urandom), int'($urandom_range(1, 4)));
            end else if (op <= 8) begin
                cpu_read(2'($urandom), int'($urandom_range(1, 4)),
                         ($urandom_range(0, 3) == 0), 8'($urandom));
            end else if ($urandom_range(0, 3) == 0) begin
                soft_reset(int'($urandom_range(1, 3)));
            end else begin
                main_flag = 1'($urandom);
                tick();
                check_state("idle");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
